// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Handshake: none; stall holds the stage, flush inserts a bubble, load_use asks ID/IF to stall.
module id_ex_stage #(
  parameter int N = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [N:0]   id_rs_data,
  input  logic [N:0]   id_rt_data,
  input  logic [15:0]  id_imm,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_wreg,
  input  logic [5:0]   id_op,
  input  logic         id_alu_src,
  input  logic         id_imm_sext,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         id_mem_to_reg,
  input  logic         exmem_reg_write,
  input  logic         memwb_reg_write,
  input  logic [4:0]   exmem_wreg,
  input  logic [4:0]   memwb_wreg,
  input  logic [N:0]   exmem_result,
  input  logic [N:0]   memwb_data,
  output logic [N:0]   alu_a,
  output logic [N:0]   alu_b,
  output logic [5:0]   alu_op,
  output logic [N:0]   ex_store_data,
  output logic [4:0]   ex_wreg,
  output logic         ex_valid,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_mem_to_reg,
  output logic         load_use
);

  logic         r_valid;
  logic [N:0]   r_rs_data;
  logic [N:0]   r_rt_data;
  logic [15:0]  r_imm;
  logic [4:0]   r_rs;
  logic [4:0]   r_rt;
  logic [4:0]   r_wreg;
  logic [5:0]   r_op;
  logic         r_alu_src;
  logic         r_imm_sext;
  logic         r_reg_write;
  logic         r_mem_read;
  logic         r_mem_write;
  logic         r_mem_to_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wreg       <= '0;
      r_op         <= 6'b000000;
      r_alu_src    <= 1'b0;
      r_imm_sext   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_wreg       <= id_wreg;
      r_op         <= id_op;
      r_alu_src    <= id_alu_src;
      r_imm_sext   <= id_imm_sext;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_mem_to_reg <= id_mem_to_reg;
    end
  end

  logic [N:0] fwd_rs;
  logic [N:0] fwd_rt;
  logic [N:0] ext_imm;
  logic [N:0] zext_imm;

  // EX/MEM is younger than MEM/WB, so it is checked first; r0 is never forwarded.
  always_comb begin
    fwd_rs = r_rs_data;
    if (exmem_reg_write && exmem_wreg != 5'd0 && exmem_wreg == r_rs)
      fwd_rs = exmem_result;
    else if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == r_rs)
      fwd_rs = memwb_data;

    fwd_rt = r_rt_data;
    if (exmem_reg_write && exmem_wreg != 5'd0 && exmem_wreg == r_rt)
      fwd_rt = exmem_result;
    else if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == r_rt)
      fwd_rt = memwb_data;
  end

  assign zext_imm = {{(N-15){1'b0}}, r_imm};
  assign ext_imm  = r_imm_sext ? {{(N-15){r_imm[15]}}, r_imm} : zext_imm;

  // Shifts take the shifted value from rt; the amount comes from shamt (in imm) or rs.
  always_comb begin
    alu_a = fwd_rs;
    alu_b = r_alu_src ? ext_imm : fwd_rt;
    case (r_op)
      6'b000000, 6'b000010, 6'b000011: begin
        alu_a = fwd_rt;
        alu_b = zext_imm;
      end
      6'b000100, 6'b000110, 6'b000111: begin
        alu_a = fwd_rt;
        alu_b = fwd_rs;
      end
      default: ;
    endcase
  end

  assign alu_op        = r_op;
  assign ex_store_data = fwd_rt;
  assign ex_wreg       = r_wreg;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write  & r_valid;
  assign ex_mem_read   = r_mem_read   & r_valid;
  assign ex_mem_write  = r_mem_write  & r_valid;
  assign ex_mem_to_reg = r_mem_to_reg & r_valid;

  assign load_use = ex_valid & ex_mem_read & (ex_wreg != 5'd0) & id_valid &
                    ((ex_wreg == id_rs) | (ex_wreg == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single-load cases plus
// hand-written sequences for flush, load-use, stall and reset.
module tb_id_ex_stage;

  logic         clk = 1'b0;
  logic         rst_n, stall, flush, id_valid;
  logic [31:0]  id_rs_data, id_rt_data;
  logic [15:0]  id_imm;
  logic [4:0]   id_rs, id_rt, id_wreg;
  logic [5:0]   id_op;
  logic         id_alu_src, id_imm_sext;
  logic         id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic         exmem_reg_write, memwb_reg_write;
  logic [4:0]   exmem_wreg, memwb_wreg;
  logic [31:0]  exmem_result, memwb_data;
  logic [31:0]  alu_a, alu_b, ex_store_data;
  logic [5:0]   alu_op;
  logic [4:0]   ex_wreg;
  logic         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic         load_use;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.N(31)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg), .id_op(id_op),
    .id_alu_src(id_alu_src), .id_imm_sext(id_imm_sext),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_wreg(exmem_wreg), .memwb_wreg(memwb_wreg),
    .exmem_result(exmem_result), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use(load_use)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic [5:0]  op;
    logic        src, sext;
    logic [3:0]  ctl;     // {reg_write, mem_read, mem_write, mem_to_reg}
    logic        xm_en;
    logic [4:0]  xm_w;
    logic [31:0] xm_d;
    logic        mw_en;
    logic [4:0]  mw_w;
    logic [31:0] mw_d;
    logic [31:0] e_a, e_b, e_st;
    logic        e_valid;
    logic [3:0]  e_ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl_out();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
  endfunction

  task automatic drive_idle();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_wreg = 0; id_op = 0;
    id_alu_src = 0; id_imm_sext = 0;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = 4'b0000;
    exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_wreg = 0; memwb_wreg = 0; exmem_result = 0; memwb_data = 0;
  endtask

  task automatic add_vec(input string name, input logic valid,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rs_d, input logic [31:0] rt_d,
                         input logic [15:0] imm, input logic [5:0] op,
                         input logic src, input logic sext, input logic [3:0] ctl,
                         input logic xm_en, input logic [4:0] xm_w, input logic [31:0] xm_d,
                         input logic mw_en, input logic [4:0] mw_w, input logic [31:0] mw_d,
                         input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_st,
                         input logic e_valid, input logic [3:0] e_ctl);
    vec_t v;
    v.name = name; v.valid = valid; v.rs = rs; v.rt = rt; v.rs_d = rs_d; v.rt_d = rt_d;
    v.imm = imm; v.op = op; v.src = src; v.sext = sext; v.ctl = ctl;
    v.xm_en = xm_en; v.xm_w = xm_w; v.xm_d = xm_d;
    v.mw_en = mw_en; v.mw_w = mw_w; v.mw_d = mw_d;
    v.e_a = e_a; v.e_b = e_b; v.e_st = e_st; v.e_valid = e_valid; v.e_ctl = e_ctl;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_wreg = 5'd10;
    id_rs_data = v.rs_d; id_rt_data = v.rt_d; id_imm = v.imm; id_op = v.op;
    id_alu_src = v.src; id_imm_sext = v.sext;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = v.ctl;
    exmem_reg_write = v.xm_en; exmem_wreg = v.xm_w; exmem_result = v.xm_d;
    memwb_reg_write = v.mw_en; memwb_wreg = v.mw_w; memwb_data = v.mw_d;
    @(posedge clk); #1;
    chk({v.name, " alu_a"}, alu_a, v.e_a);
    chk({v.name, " alu_b"}, alu_b, v.e_b);
    chk({v.name, " alu_op"}, {26'd0, alu_op}, {26'd0, v.op});
    chk({v.name, " store"}, ex_store_data, v.e_st);
    chk({v.name, " valid"}, {31'd0, ex_valid}, {31'd0, v.e_valid});
    chk({v.name, " ctl"}, {28'd0, ctl_out()}, {28'd0, v.e_ctl});
  endtask

  task automatic chk_zero(input string name);
    chk({name, " alu_a"}, alu_a, 0);
    chk({name, " alu_b"}, alu_b, 0);
    chk({name, " alu_op"}, {26'd0, alu_op}, 0);
    chk({name, " store"}, ex_store_data, 0);
    chk({name, " wreg"}, {27'd0, ex_wreg}, 0);
    chk({name, " valid"}, {31'd0, ex_valid}, 0);
    chk({name, " ctl"}, {28'd0, ctl_out()}, 0);
    chk({name, " load_use"}, {31'd0, load_use}, 0);
  endtask

  initial begin
    //        name       v  rs rt rs_d          rt_d          imm       op         src sext ctl      xm: en w  d              mw: en w d          e_a           e_b           e_st          ev e_ctl
    add_vec("addu",      1, 3, 4, 32'd5,        32'd7,        16'h0000, 6'b100001, 0, 0, 4'b1000, 0, 0, 0,             0, 0, 0,            32'd5,        32'd7,        32'd7,        1, 4'b1000);
    add_vec("fwd_both",  1, 8, 4, 32'h1234,     32'd7,        16'h0000, 6'b100001, 0, 0, 4'b1000, 1, 8, 32'hAAAA0000, 1, 8, 32'h11,       32'hAAAA0000, 32'd7,        32'd7,        1, 4'b1000);
    add_vec("fwd_mw",    1, 8, 4, 32'h1234,     32'd7,        16'h0000, 6'b100001, 0, 0, 4'b1000, 0, 8, 32'hAAAA0000, 1, 8, 32'h11,       32'h11,       32'd7,        32'd7,        1, 4'b1000);
    add_vec("fwd_r0",    1, 0, 4, 32'd5,        32'd7,        16'h0000, 6'b100001, 0, 0, 4'b1000, 1, 0, 32'hAAAA0000, 1, 0, 32'h11,       32'd5,        32'd7,        32'd7,        1, 4'b1000);
    add_vec("fwd_rt",    1, 3, 6, 32'd5,        32'd7,        16'h0000, 6'b100001, 0, 0, 4'b1010, 0, 0, 0,             1, 6, 32'h99,       32'd5,        32'h99,       32'h99,       1, 4'b1010);
    add_vec("sra",       1, 3, 4, 32'd5,        32'h80000000, 16'h0100, 6'b000011, 0, 1, 4'b1000, 0, 0, 0,             0, 0, 0,            32'h80000000, 32'h100,      32'h80000000, 1, 4'b1000);
    add_vec("srav",      1, 3, 4, 32'd4,        32'h80000000, 16'h0100, 6'b000111, 1, 0, 4'b1000, 0, 0, 0,             0, 0, 0,            32'h80000000, 32'd4,        32'h80000000, 1, 4'b1000);
    add_vec("imm_sext",  1, 3, 4, 32'd1,        32'd7,        16'hFFFC, 6'b100001, 1, 1, 4'b1000, 0, 0, 0,             0, 0, 0,            32'd1,        32'hFFFFFFFC, 32'd7,        1, 4'b1000);
    add_vec("imm_zext",  1, 3, 4, 32'd1,        32'd7,        16'hFFFC, 6'b100001, 1, 0, 4'b1000, 0, 0, 0,             0, 0, 0,            32'd1,        32'h0000FFFC, 32'd7,        1, 4'b1000);
    add_vec("invalid",   0, 3, 4, 32'd2,        32'd3,        16'h0000, 6'b100001, 0, 0, 4'b1111, 0, 0, 0,             0, 0, 0,            32'd2,        32'd3,        32'd3,        0, 4'b0000);

    // reset
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // flush overrides a pending load
    @(negedge clk);
    drive_idle();
    id_valid = 1; id_rs = 3; id_rs_data = 32'd9; id_op = 6'b100001; id_wreg = 5'd7;
    id_reg_write = 1; flush = 1;
    @(posedge clk); #1 chk_zero("flush");

    // load-use: EX holds lw r9
    @(negedge clk);
    drive_idle();
    id_valid = 1; id_rs = 2; id_wreg = 5'd9; id_op = 6'b100011 ^ 6'b000010;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    @(posedge clk); #1;
    chk("lw ex_wreg", {27'd0, ex_wreg}, 32'd9);
    chk("lw mem_read", {31'd0, ex_mem_read}, 1);
    @(negedge clk);
    stall = 1;
    id_valid = 1; id_rs = 1; id_rt = 9; id_mem_read = 0; id_mem_to_reg = 0;
    #1 chk("lu rt", {31'd0, load_use}, 1);
    id_rt = 5; id_rs = 9;
    #1 chk("lu rs", {31'd0, load_use}, 1);
    id_rs = 5;
    #1 chk("lu none", {31'd0, load_use}, 0);
    id_rt = 9; id_valid = 0;
    #1 chk("lu id_inv", {31'd0, load_use}, 0);
    id_valid = 1; flush = 1;
    #1 chk("lu w/ flush", {31'd0, load_use}, 1);
    @(posedge clk); #1;
    chk("lu bubble valid", {31'd0, ex_valid}, 0);
    chk("lu bubble rw", {31'd0, ex_reg_write}, 0);
    chk("lu bubble wreg", {27'd0, ex_wreg}, 0);
    chk("lu after", {31'd0, load_use}, 0);

    // stall 3 cycles, then reset while stalled
    @(negedge clk);
    drive_idle();
    id_valid = 1; id_rs = 3; id_rt = 4; id_rs_data = 32'd5; id_rt_data = 32'd7;
    id_op = 6'b100001; id_wreg = 5'd12; id_reg_write = 1;
    @(posedge clk); #1 chk("pre-stall a", alu_a, 32'd5);
    @(negedge clk);
    stall = 1; id_rs_data = 32'd99; id_rt_data = 32'd98; id_op = 6'b100011; id_wreg = 5'd1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall a", alu_a, 32'd5);
      chk("stall b", alu_b, 32'd7);
      chk("stall op", {26'd0, alu_op}, 32'h21);
      chk("stall wreg", {27'd0, ex_wreg}, 32'd12);
      chk("stall rw", {31'd0, ex_reg_write}, 1);
    end
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1 chk_zero("reset mid-stall");
    @(negedge clk);
    rst_n = 1; stall = 0; id_rs_data = 32'h21;
    @(posedge clk); #1;
    chk("post-reset a", alu_a, 32'h21);
    chk("post-reset valid", {31'd0, ex_valid}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: N, 31, data MSB index; datapaths are [N:0].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 stall  in  1  hold all stage registers.
REQ-005 flush  in  1  load a bubble on next edge.
REQ-006 id_valid  in  1  ID slot holds a real instruction.
REQ-007 id_rs_data, id_rt_data  in  N+1 each  register-file read values.
REQ-008 id_imm  in  16  instruction[15:0].
REQ-009 id_rs, id_rt, id_wreg  in  5 each  source regs; destination after RegDst.
REQ-010 id_op  in  6  ALU function code (ALU encodings: ADDU 100001 ... SRAV 000111).
REQ-011 id_alu_src, id_imm_sext  in  1 each  B from immediate; sign- (1) or zero- (0) extend.
REQ-012 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  controls.
REQ-013 exmem_reg_write, memwb_reg_write  in  1 each;  exmem_wreg, memwb_wreg  in  5 each;  exmem_result, memwb_data  in  N+1 each  forwarding sources.
REQ-014 alu_a, alu_b  out  N+1 each;  alu_op  out  6  ALU operands/function.
REQ-015 ex_store_data  out  N+1  forwarded rt value for stores.
REQ-016 ex_wreg  out  5;  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
REQ-017 load_use  out  1  combinational stall request to ID/IF.

Function
REQ-018 Registered fields: valid, rs_data, rt_data, imm, rs, rt, wreg, op, alu_src, imm_sext, four controls.
REQ-019 Per edge priority: !rst_n > flush > stall > load; load copies every id_* input, 1-cycle latency.
REQ-020 Bubble: valid, reg_write, mem_read, mem_write, mem_to_reg = 0; wreg = 0; op = 6'b000000; data fields = 0.
REQ-021 stall=1, flush=0: every register keeps its value; outputs stable.
REQ-022 Controls leave as registered value AND valid (invalid slot never writes/accesses memory).
REQ-023 Forwarded rs (fwd_rs): exmem_result if exmem_reg_write & exmem_wreg!=0 & exmem_wreg==rs; else memwb_data if memwb_reg_write & memwb_wreg!=0 & memwb_wreg==rs; else registered rs_data. fwd_rt identical for rt.
REQ-024 Both forwarding sources matching: EX/MEM wins; register 0 never forwarded (reads 0 from regs).
REQ-025 ext_imm = {{(N-15){imm[15]}},imm} if imm_sext, else zero-extended imm.
REQ-026 op in {000000,000010,000011} (SLL/SRL/SRA): alu_a = fwd_rt, alu_b = zero-extended imm (shamt lands in B[10:6]).
REQ-027 op in {000100,000110,000111} (SLLV/SRLV/SRAV): alu_a = fwd_rt, alu_b = fwd_rs.
REQ-028 Other op: alu_a = fwd_rs, alu_b = alu_src ? ext_imm : fwd_rt.
REQ-029 alu_op = registered op; ex_store_data = fwd_rt always.
REQ-030 Operand muxing and forwarding purely combinational from registers and current forwarding inputs.
REQ-031 load_use = ex_valid & ex_mem_read & ex_wreg!=0 & id_valid & (ex_wreg==id_rs | ex_wreg==id_rt).
REQ-032 load_use independent of stall/flush; external logic drives flush=1 to this stage while load_use=1.

Reset
REQ-033 rst_n=0 at an edge: stage registers loaded with bubble (REQ-020), overriding flush/stall/id inputs.
REQ-034 After reset: alu_a=alu_b=0, alu_op=0, ex_store_data=0, ex_wreg=0, all controls and ex_valid=0, load_use=0 (absent forwarding matches).
REQ-035 Reset asserted mid-stall discards held instruction; first edge with rst_n=1 loads normally.

Verification
REQ-036 ADDU load: rs=3 data 5, rt=4 data 7, op=100001, no fwd -> next cycle alu_a=5, alu_b=7, alu_op=100001, ex_valid=1.
REQ-037 Double forward: registered rs=8; exmem_wreg=8 result 0xAAAA0000, memwb_wreg=8 data 0x11 both write -> alu_a=0xAAAA0000; drop exmem_reg_write -> 0x11; rs=0 with matches -> register value.
REQ-038 Shift: op=000011, rt data 0x80000000, imm=0x0100 -> alu_a=0x80000000, alu_b=0x00000100; op=000111 rs data 4 -> alu_b=4.
REQ-039 Immediate: alu_src=1, imm=0xFFFC, sext=1 -> alu_b=0xFFFFFFFC; sext=0 -> 0x0000FFFC.
REQ-040 Load-use: EX holds lw to r9, ID rt=9 -> load_use=1; flush+stall same edge -> bubble, ex_reg_write=0.
REQ-041 Stall 3 cycles then reset: outputs frozen 3 cycles, then all zero per REQ-034.
